// File: rtl/parity_frame_gen.sv
// parity_frame_gen
// Streaming parity generator. Folds the parity of every word of a frame
// (delimited by inLast, or force-closed after MAX_WORDS words) into a single
// bit and presents parity, word count and an overflow flag on a valid/ready
// result port. One bubble cycle per frame while the result is handed off.
module parity_frame_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oddMode,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  input  logic             inLast,
  output logic             inReady,
  output logic             outParity,
  output logic [CW-1:0]    outCount,
  output logic             outError,
  output logic             outValid,
  input  logic             outReady
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          acc;
  logic [CW-1:0] cnt;
  logic          mode_reg;

  logic          accept;
  logic          word_par;
  logic          frame_mode;
  logic          max_hit;
  logic          closing;
  logic          release_res;

  // inReady depends on state only, so no combinational input-to-output path.
  assign inReady = (state == RUN) & ~rst;

  // Frame bookkeeping decodes and next-state selection.
  always_comb begin
    accept      = inValid & inReady;
    word_par    = ^inData;
    // The mode register is only loaded on the first word, so that word uses
    // the live pin value.
    frame_mode  = (cnt == '0) ? oddMode : mode_reg;
    max_hit     = (cnt == CW'(MAX_WORDS - 1));
    closing     = inLast | max_hit;
    release_res = outValid & outReady;
    state_nxt   = state;
    case (state)
      RUN:     if (accept && closing) state_nxt = HOLD;
      HOLD:    if (release_res)       state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Parity accumulation, result capture and result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= 1'b0;
      cnt       <= '0;
      mode_reg  <= 1'b0;
      outValid  <= 1'b0;
      outParity <= 1'b0;
      outCount  <= '0;
      outError  <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt == '0) mode_reg <= oddMode;
        if (closing) begin
          outParity <= acc ^ word_par ^ frame_mode;
          outCount  <= cnt + CW'(1);
          outError  <= ~inLast;
          outValid  <= 1'b1;
        end else begin
          acc <= acc ^ word_par;
          cnt <= cnt + CW'(1);
        end
      end
      // Partial state is cleared only once the consumer has the result.
      if (state == HOLD && release_res) begin
        outValid <= 1'b0;
        acc      <= 1'b0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_gen.sv
// Directed bench for parity_frame_gen: a WIDTH=4/MAX_WORDS=16 instance and a
// WIDTH=8/MAX_WORDS=4 instance share clock and reset.
module tb_parity_frame_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=4, MAX_WORDS=16 instance
  logic       odd4 = 1'b0, v4 = 1'b0, l4 = 1'b0, rdy4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       ir4, par4, err4, ov4;
  logic [4:0] cnt4;

  // WIDTH=8, MAX_WORDS=4 instance
  logic       odd8 = 1'b0, v8 = 1'b0, l8 = 1'b0, rdy8 = 1'b0;
  logic [7:0] d8 = '0;
  logic       ir8, par8, err8, ov8;
  logic [2:0] cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_gen #(.WIDTH(4), .MAX_WORDS(16)) u4 (
    .clk(clk), .rst(rst), .oddMode(odd4), .inData(d4), .inValid(v4),
    .inLast(l4), .inReady(ir4), .outParity(par4), .outCount(cnt4),
    .outError(err4), .outValid(ov4), .outReady(rdy4)
  );

  parity_frame_gen #(.WIDTH(8), .MAX_WORDS(4)) u8 (
    .clk(clk), .rst(rst), .oddMode(odd8), .inData(d8), .inValid(v8),
    .inLast(l8), .inReady(ir8), .outParity(par8), .outCount(cnt8),
    .outError(err8), .outValid(ov8), .outReady(rdy8)
  );

  // Present one word for one rising edge; returns at the following falling edge.
  task automatic word4(input logic [3:0] d, input logic last, input logic m);
    d4 = d; l4 = last; odd4 = m; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0; l4 = 1'b0;
  endtask

  task automatic word8(input logic [7:0] d, input logic last, input logic m);
    d8 = d; l8 = last; odd8 = m; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; l8 = 1'b0;
  endtask

  // Hold outReady for one edge so a pending result is taken.
  task automatic take4();
    rdy4 = 1'b1;
    @(negedge clk);
    rdy4 = 1'b0;
  endtask

  task automatic take8();
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ov4, par4, cnt4, err4, ir4} !== 9'b0) begin
      errors++;
      $display("FAIL reset_u4: got v=%b p=%b c=%0d e=%b rdy=%b, want all 0",
               ov4, par4, cnt4, err4, ir4);
    end
    checks++;
    if ({ov8, par8, cnt8, err8, ir8} !== 7'b0) begin
      errors++;
      $display("FAIL reset_u8: got v=%b p=%b c=%0d e=%b rdy=%b, want all 0",
               ov8, par8, cnt8, err8, ir8);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir4, ir8, ov4, ov8} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: got rdy4=%b rdy8=%b v4=%b v8=%b, want 1 1 0 0",
               ir4, ir8, ov4, ov8);
    end
  endtask

  task automatic test_single_even();
    word4(4'h4, 1'b1, 1'b0);
    checks++;
    if ({ov4, par4, cnt4, err4, ir4} !== {1'b1, 1'b1, 5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL even_4h4: got v=%b p=%b c=%0d e=%b rdy=%b, want v=1 p=1 c=1 e=0 rdy=0",
               ov4, par4, cnt4, err4, ir4);
    end
    take4();
    checks++;
    if ({ov4, ir4} !== 2'b01) begin
      errors++;
      $display("FAIL handoff_u4: got v=%b rdy=%b, want v=0 rdy=1", ov4, ir4);
    end
    word4(4'hF, 1'b1, 1'b0);
    checks++;
    if ({ov4, par4, cnt4, err4} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL even_4hF: got v=%b p=%b c=%0d e=%b, want v=1 p=0 c=1 e=0",
               ov4, par4, cnt4, err4);
    end
    take4();
  endtask

  task automatic test_odd_mode();
    word4(4'hF, 1'b1, 1'b1);
    checks++;
    if ({ov4, par4, cnt4} !== {1'b1, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL odd_4hF: got v=%b p=%b c=%0d, want v=1 p=1 c=1", ov4, par4, cnt4);
    end
    take4();
    word4(4'h1, 1'b0, 1'b1);
    word4(4'h0, 1'b1, 1'b0);
    checks++;
    if ({ov4, par4, cnt4, err4} !== {1'b1, 1'b0, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL odd_mode_kept: got v=%b p=%b c=%0d e=%b, want v=1 p=0 c=2 e=0",
               ov4, par4, cnt4, err4);
    end
    take4();
  endtask

  task automatic test_back_to_back();
    word8(8'h01, 1'b0, 1'b0);
    checks++;
    if ({ir8, ov8} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_mid_frame: got rdy=%b v=%b, want rdy=1 v=0", ir8, ov8);
    end
    word8(8'h03, 1'b0, 1'b0);
    word8(8'h07, 1'b1, 1'b0);
    checks++;
    if ({ov8, par8, cnt8, err8, ir8} !== {1'b1, 1'b0, 3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_frame: got v=%b p=%b c=%0d e=%b rdy=%b, want v=1 p=0 c=3 e=0 rdy=0",
               ov8, par8, cnt8, err8, ir8);
    end
    take8();
  endtask

  task automatic test_backpressure();
    word8(8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      d8 = 8'($urandom); l8 = 1'($urandom); v8 = 1'b1;
      @(negedge clk);
      checks++;
      if ({ov8, par8, cnt8, err8, ir8} !== {1'b1, 1'b1, 3'd1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got v=%b p=%b c=%0d e=%b rdy=%b, want v=1 p=1 c=1 e=0 rdy=0",
                 i, ov8, par8, cnt8, err8, ir8);
      end
    end
    v8 = 1'b0; l8 = 1'b0;
    rdy8 = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release_edge: got rdy=%b, want 0", ir8);
    end
    @(negedge clk);
    rdy8 = 1'b0;
    checks++;
    if ({ov8, ir8} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got v=%b rdy=%b, want v=0 rdy=1", ov8, ir8);
    end
    // A fresh single-word frame shows nothing was swallowed while held.
    word8(8'h03, 1'b1, 1'b0);
    checks++;
    if ({ov8, par8, cnt8} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL backpressure_no_consume: got v=%b p=%b c=%0d, want v=1 p=0 c=1",
               ov8, par8, cnt8);
    end
    take8();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) word8(8'h01, 1'b0, 1'b0);
    checks++;
    if ({ov8, par8, cnt8, err8} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL overflow_close: got v=%b p=%b c=%0d e=%b, want v=1 p=0 c=4 e=1",
               ov8, par8, cnt8, err8);
    end
    take8();
    word8(8'h01, 1'b1, 1'b0);
    checks++;
    if ({ov8, par8, cnt8, err8} !== {1'b1, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL overflow_next_frame: got v=%b p=%b c=%0d e=%b, want v=1 p=1 c=1 e=0",
               ov8, par8, cnt8, err8);
    end
    take8();
    for (int i = 0; i < 3; i++) word8(8'h01, 1'b0, 1'b0);
    word8(8'h01, 1'b1, 1'b0);
    checks++;
    if ({ov8, par8, cnt8, err8} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL last_at_max: got v=%b p=%b c=%0d e=%b, want v=1 p=0 c=4 e=0",
               ov8, par8, cnt8, err8);
    end
    take8();
    // Leave a non-zero result behind so the reset test can see it cleared.
    word8(8'h01, 1'b1, 1'b0);
    take8();
  endtask

  task automatic test_async_reset();
    word8(8'h01, 1'b0, 1'b0);
    word8(8'h01, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ov8, par8, cnt8, err8, ir8} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b p=%b c=%0d e=%b rdy=%b, want all 0",
               ov8, par8, cnt8, err8, ir8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    word8(8'h01, 1'b1, 1'b0);
    checks++;
    if ({ov8, par8, cnt8, err8} !== {1'b1, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_frame: got v=%b p=%b c=%0d e=%b, want v=1 p=1 c=1 e=0",
               ov8, par8, cnt8, err8);
    end
    take8();
  endtask

  initial begin
    test_reset();
    test_single_even();
    test_odd_mode();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
